// File: rtl/mem_arbiter_rr_if.sv
// Cache-side request/response channels and the shared RAM port, bundled as one interface.
// The arbiter connects through the slave modport; caches and RAM sit on the master side.
interface mem_arbiter_rr_if #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32
);
    logic [CPUS-1:0]        iREN;
    logic [CPUS*ADDR_W-1:0] iaddr;
    logic [CPUS-1:0]        dREN;
    logic [CPUS-1:0]        dWEN;
    logic [CPUS*ADDR_W-1:0] daddr;
    logic [CPUS*WORD_W-1:0] dstore;
    logic [CPUS-1:0]        iwait;
    logic [CPUS-1:0]        dwait;
    logic [CPUS*WORD_W-1:0] iload;
    logic [CPUS*WORD_W-1:0] dload;
    logic [ADDR_W-1:0]      ramaddr;
    logic [WORD_W-1:0]      ramstore;
    logic                   ramREN;
    logic                   ramWEN;
    logic [WORD_W-1:0]      ramload;
    logic [1:0]             ramstate;
    logic                   ram_err;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN, ram_err
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, dwait, iload, dload, ramaddr, ramstore, ramREN, ramWEN, ram_err
    );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter of CPUS instruction+data cache channels onto one shared RAM port.
// Channel 2c is cache c data, 2c+1 is cache c instruction; one grant in flight at a time.
module mem_arbiter_rr #(
    parameter int CPUS   = 2,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 32
) (
    input logic              CLK,
    input logic              nRST,
    mem_arbiter_rr_if.slave  bus
);
    localparam int N  = 2 * CPUS;
    localparam int IW = $clog2(N);

    localparam logic [1:0] RS_ACCESS = 2'd2;
    localparam logic [1:0] RS_ERROR  = 2'd3;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr, ptr_nxt;
    logic [IW-1:0]   owner, owner_nxt;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   owner_inc;
    logic [N-1:0]    req;
    logic            own_req;

    logic [ADDR_W-1:0] ch_addr  [N];
    logic [WORD_W-1:0] ch_store [N];
    logic              ch_ren   [N];
    logic              ch_wen   [N];

    // Flatten each cache into its two channels; a data write wins over a data read.
    for (genvar c = 0; c < CPUS; c++) begin : g_cache
        assign req[2*c]        = bus.dREN[c] | bus.dWEN[c];
        assign req[2*c+1]      = bus.iREN[c];
        assign ch_addr[2*c]    = bus.daddr[c*ADDR_W +: ADDR_W];
        assign ch_addr[2*c+1]  = bus.iaddr[c*ADDR_W +: ADDR_W];
        assign ch_store[2*c]   = bus.dstore[c*WORD_W +: WORD_W];
        assign ch_store[2*c+1] = '0;
        assign ch_ren[2*c]     = bus.dREN[c] & ~bus.dWEN[c];
        assign ch_ren[2*c+1]   = bus.iREN[c];
        assign ch_wen[2*c]     = bus.dWEN[c];
        assign ch_wen[2*c+1]   = 1'b0;
    end

    assign owner_inc = (owner == IW'(N - 1)) ? '0 : owner + 1'b1;
    assign own_req   = req[owner];

    // Scan downward in offset so the lowest offset from ptr is the one that sticks.
    always_comb begin
        int unsigned idx;
        idx  = 0;
        pick = ptr;
        for (int k = N - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % N;
            if (req[idx]) pick = IW'(idx);
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
            ptr   <= '0;
            owner <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
        end
    end

    always_comb begin
        int cidx;
        cidx         = int'(owner) / 2;
        state_nxt    = state;
        ptr_nxt      = ptr;
        owner_nxt    = owner;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = '1;
        bus.dwait    = '1;
        bus.iload    = '0;
        bus.dload    = '0;
        bus.ram_err  = 1'b0;

        // Reset masks every output so an access in flight is aborted without an ack.
        if (nRST) begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        owner_nxt = pick;
                        state_nxt = BUSY;
                    end
                end
                BUSY: begin
                    bus.ramaddr  = ch_addr[owner];
                    bus.ramstore = ch_store[owner];
                    if (!own_req) begin
                        state_nxt = IDLE;
                        ptr_nxt   = owner_inc;
                    end else begin
                        bus.ramREN = ch_ren[owner];
                        bus.ramWEN = ch_wen[owner];
                        case (bus.ramstate)
                            RS_ACCESS: begin
                                if (owner[0]) begin
                                    bus.iwait[cidx]                 = 1'b0;
                                    bus.iload[cidx*WORD_W +: WORD_W] = bus.ramload;
                                end else begin
                                    bus.dwait[cidx]                 = 1'b0;
                                    bus.dload[cidx*WORD_W +: WORD_W] = bus.ramload;
                                end
                                state_nxt = IDLE;
                                ptr_nxt   = owner_inc;
                            end
                            // ptr is left alone so the failed channel can be retried.
                            RS_ERROR: begin
                                bus.ram_err = 1'b1;
                                state_nxt   = IDLE;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr (CPUS=2): constant vector table, hand-written corner sequences,
// then random traffic against a channel-level reference model.
module tb_mem_arbiter_rr;
    localparam int CPUS = 2;
    localparam int N    = 2 * CPUS;

    logic CLK;
    logic nRST;
    int   errors = 0;
    int   checks = 0;

    int m_busy  = 0;
    int m_owner = 0;
    int m_ptr   = 0;

    mem_arbiter_rr_if #(.CPUS(CPUS), .WORD_W(32), .ADDR_W(32)) bus ();

    mem_arbiter_rr #(.CPUS(CPUS), .WORD_W(32), .ADDR_W(32)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit        nrst;
        bit [1:0]  ir, dr, dw, rs;
        bit        ren, wen, err;
        bit [31:0] addr, store;
        bit [1:0]  iw, dwt;
        bit [63:0] il, dl;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl [NV];

    localparam bit [63:0] LO = 64'h0000_0000_DEAD_BEEF;
    localparam bit [63:0] HI = 64'hDEAD_BEEF_0000_0000;

    function automatic vec_t v(bit nrst, bit [1:0] ir, bit [1:0] dr, bit [1:0] dw, bit [1:0] rs,
                               bit ren, bit wen, bit err, bit [31:0] addr, bit [31:0] store,
                               bit [1:0] iw, bit [1:0] dwt, bit [63:0] il, bit [63:0] dl);
        vec_t r;
        r.nrst = nrst; r.ir = ir; r.dr = dr; r.dw = dw; r.rs = rs;
        r.ren = ren; r.wen = wen; r.err = err; r.addr = addr; r.store = store;
        r.iw = iw; r.dwt = dwt; r.il = il; r.dl = dl;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input bit nrst, input bit [1:0] ir, input bit [1:0] dr,
                          input bit [1:0] dw, input bit [1:0] rs);
        nRST = nrst; bus.iREN = ir; bus.dREN = dr; bus.dWEN = dw; bus.ramstate = rs;
    endtask

    function automatic bit chreq(int k);
        if (k % 2 == 0) return bus.dREN[k/2] | bus.dWEN[k/2];
        return bus.iREN[k/2];
    endfunction

    // Channel-level model: idle/busy, owner and ptr as plain integers.
    task automatic model_update();
        bit found;
        found = 1'b0;
        if (!nRST) begin
            m_busy = 0; m_ptr = 0; m_owner = 0;
        end else if (m_busy == 0) begin
            for (int k = 0; k < N; k++) begin
                if (!found && chreq((m_ptr + k) % N)) begin
                    m_owner = (m_ptr + k) % N;
                    m_busy  = 1;
                    found   = 1'b1;
                end
            end
        end else if (!chreq(m_owner) || bus.ramstate == 2'd2) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % N;
        end else if (bus.ramstate == 2'd3) begin
            m_busy = 0;
        end
    endtask

    task automatic check_model(input int cyc);
        logic        e_ren, e_wen, e_err;
        logic [31:0] e_addr, e_store;
        logic [1:0]  e_iw, e_dw;
        logic [63:0] e_il, e_dl;
        int          c;
        e_ren = 0; e_wen = 0; e_err = 0; e_addr = 0; e_store = 0;
        e_iw = '1; e_dw = '1; e_il = 0; e_dl = 0;
        c = m_owner / 2;
        if (nRST && m_busy != 0) begin
            if (m_owner % 2 == 0) begin
                e_addr  = bus.daddr[c*32 +: 32];
                e_store = bus.dstore[c*32 +: 32];
            end else begin
                e_addr  = bus.iaddr[c*32 +: 32];
            end
            if (chreq(m_owner)) begin
                if (m_owner % 2 == 0) begin
                    e_wen = bus.dWEN[c];
                    e_ren = bus.dREN[c] & ~bus.dWEN[c];
                end else begin
                    e_ren = 1'b1;
                end
                if (bus.ramstate == 2'd2) begin
                    if (m_owner % 2 == 0) begin
                        e_dw[c] = 1'b0; e_dl[c*32 +: 32] = bus.ramload;
                    end else begin
                        e_iw[c] = 1'b0; e_il[c*32 +: 32] = bus.ramload;
                    end
                end else if (bus.ramstate == 2'd3) begin
                    e_err = 1'b1;
                end
            end
        end
        chk($sformatf("rand%0d ramREN", cyc),   bus.ramREN,   e_ren);
        chk($sformatf("rand%0d ramWEN", cyc),   bus.ramWEN,   e_wen);
        chk($sformatf("rand%0d ram_err", cyc),  bus.ram_err,  e_err);
        chk($sformatf("rand%0d ramaddr", cyc),  bus.ramaddr,  e_addr);
        chk($sformatf("rand%0d ramstore", cyc), bus.ramstore, e_store);
        chk($sformatf("rand%0d iwait", cyc),    bus.iwait,    e_iw);
        chk($sformatf("rand%0d dwait", cyc),    bus.dwait,    e_dw);
        chk($sformatf("rand%0d iload", cyc),    bus.iload,    e_il);
        chk($sformatf("rand%0d dload", cyc),    bus.dload,    e_dl);
    endtask

    task automatic to_next();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    initial begin
        tbl[0]  = v(0, 2'b11, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 2'b11, 0, 0);
        tbl[1]  = v(0, 2'b11, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 2'b11, 0, 0);
        tbl[2]  = v(1, 2'b11, 2'b11, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 2'b11, 0, 0);
        tbl[3]  = v(1, 2'b11, 2'b11, 2'b00, 2, 1, 0, 0, 32'h100, 32'h12345678, 2'b11, 2'b10, 0, LO);
        tbl[4]  = v(1, 2'b11, 2'b11, 2'b00, 2, 0, 0, 0, 0, 0, 2'b11, 2'b11, 0, 0);
        tbl[5]  = v(1, 2'b11, 2'b11, 2'b00, 2, 1, 0, 0, 32'h20, 0, 2'b10, 2'b11, LO, 0);
        tbl[6]  = v(1, 2'b11, 2'b11, 2'b00, 2, 0, 0, 0, 0, 0, 2'b11, 2'b11, 0, 0);
        tbl[7]  = v(1, 2'b11, 2'b11, 2'b00, 2, 1, 0, 0, 32'h200, 32'hCAFEF00D, 2'b11, 2'b01, 0, HI);
        tbl[8]  = v(1, 2'b11, 2'b11, 2'b00, 2, 0, 0, 0, 0, 0, 2'b11, 2'b11, 0, 0);
        tbl[9]  = v(1, 2'b11, 2'b11, 2'b00, 2, 1, 0, 0, 32'h40, 0, 2'b01, 2'b11, HI, 0);
        tbl[10] = v(1, 2'b11, 2'b11, 2'b00, 2, 0, 0, 0, 0, 0, 2'b11, 2'b11, 0, 0);
        tbl[11] = v(1, 2'b11, 2'b11, 2'b00, 2, 1, 0, 0, 32'h100, 32'h12345678, 2'b11, 2'b10, 0, LO);
        tbl[12] = v(1, 2'b00, 2'b01, 2'b01, 0, 0, 0, 0, 0, 0, 2'b11, 2'b11, 0, 0);
        tbl[13] = v(1, 2'b00, 2'b01, 2'b01, 1, 0, 1, 0, 32'h100, 32'h12345678, 2'b11, 2'b11, 0, 0);
        tbl[14] = v(1, 2'b00, 2'b01, 2'b01, 2, 0, 1, 0, 32'h100, 32'h12345678, 2'b11, 2'b10, 0, LO);
        tbl[15] = v(1, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 2'b11, 0, 0);
        tbl[16] = v(1, 2'b10, 2'b00, 2'b00, 0, 1, 0, 0, 32'h40, 0, 2'b11, 2'b11, 0, 0);
        tbl[17] = v(1, 2'b10, 2'b00, 2'b00, 1, 1, 0, 0, 32'h40, 0, 2'b11, 2'b11, 0, 0);
        tbl[18] = v(1, 2'b10, 2'b00, 2'b00, 1, 1, 0, 0, 32'h40, 0, 2'b11, 2'b11, 0, 0);
        tbl[19] = v(1, 2'b10, 2'b00, 2'b00, 2, 1, 0, 0, 32'h40, 0, 2'b01, 2'b11, HI, 0);
        tbl[20] = v(1, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 2'b11, 2'b11, 0, 0);

        set_in(0, 2'b00, 2'b00, 2'b00, 0);
        bus.iaddr   = {32'h40, 32'h20};
        bus.daddr   = {32'h200, 32'h100};
        bus.dstore  = {32'hCAFEF00D, 32'h12345678};
        bus.ramload = 32'hDEADBEEF;
        @(posedge CLK);
        #1;

        // Reset, round-robin order, write priority, single delayed read.
        for (int i = 0; i < NV; i++) begin
            set_in(tbl[i].nrst, tbl[i].ir, tbl[i].dr, tbl[i].dw, tbl[i].rs);
            @(negedge CLK);
            chk($sformatf("row%0d ramREN", i),   bus.ramREN,   tbl[i].ren);
            chk($sformatf("row%0d ramWEN", i),   bus.ramWEN,   tbl[i].wen);
            chk($sformatf("row%0d ram_err", i),  bus.ram_err,  tbl[i].err);
            chk($sformatf("row%0d ramaddr", i),  bus.ramaddr,  tbl[i].addr);
            chk($sformatf("row%0d ramstore", i), bus.ramstore, tbl[i].store);
            chk($sformatf("row%0d iwait", i),    bus.iwait,    tbl[i].iw);
            chk($sformatf("row%0d dwait", i),    bus.dwait,    tbl[i].dwt);
            chk($sformatf("row%0d iload", i),    bus.iload,    tbl[i].il);
            chk($sformatf("row%0d dload", i),    bus.dload,    tbl[i].dl);
            to_next();
        end

        // Error on channel 2, then retry to completion.
        set_in(1, 2'b00, 2'b10, 2'b00, 0);
        @(negedge CLK); chk("err idle ren", bus.ramREN, 1'b0);
        to_next();
        set_in(1, 2'b00, 2'b10, 2'b00, 3);
        @(negedge CLK);
        chk("err pulse", bus.ram_err, 1'b1);
        chk("err dwait", bus.dwait, 2'b11);
        chk("err addr", bus.ramaddr, 32'h200);
        to_next();
        set_in(1, 2'b00, 2'b10, 2'b00, 0);
        @(negedge CLK);
        chk("err gap ren", bus.ramREN, 1'b0);
        chk("err gap pulse", bus.ram_err, 1'b0);
        to_next();
        set_in(1, 2'b00, 2'b10, 2'b00, 2);
        @(negedge CLK);
        chk("retry addr", bus.ramaddr, 32'h200);
        chk("retry dwait", bus.dwait, 2'b01);
        chk("retry pulse", bus.ram_err, 1'b0);
        to_next();

        // Owner withdraws mid-access: enables drop at once, no ack, ptr advances.
        set_in(1, 2'b01, 2'b00, 2'b00, 0);
        @(negedge CLK); chk("wd idle ren", bus.ramREN, 1'b0);
        to_next();
        set_in(1, 2'b01, 2'b00, 2'b00, 1);
        @(negedge CLK);
        chk("wd grant ren", bus.ramREN, 1'b1);
        chk("wd grant addr", bus.ramaddr, 32'h20);
        to_next();
        set_in(1, 2'b00, 2'b00, 2'b00, 2);
        @(negedge CLK);
        chk("wd drop ren", bus.ramREN, 1'b0);
        chk("wd no ack", bus.iwait, 2'b11);
        to_next();
        set_in(1, 2'b11, 2'b11, 2'b00, 0);
        @(negedge CLK); chk("wd after idle", bus.ramREN, 1'b0);
        to_next();
        set_in(1, 2'b11, 2'b11, 2'b00, 1);
        @(negedge CLK);
        chk("wd next owner addr", bus.ramaddr, 32'h200);
        chk("wd next owner ren", bus.ramREN, 1'b1);
        to_next();

        // Reset during BUSY aborts without ack and restarts from channel 0.
        set_in(0, 2'b11, 2'b11, 2'b00, 2);
        @(negedge CLK);
        chk("rst busy dwait", bus.dwait, 2'b11);
        chk("rst busy ren", bus.ramREN, 1'b0);
        to_next();
        set_in(1, 2'b11, 2'b11, 2'b00, 0);
        @(negedge CLK); chk("rst idle ren", bus.ramREN, 1'b0);
        to_next();
        set_in(1, 2'b11, 2'b11, 2'b00, 2);
        @(negedge CLK);
        chk("rst regrant addr", bus.ramaddr, 32'h100);
        chk("rst regrant dwait", bus.dwait, 2'b10);
        to_next();

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom_range(0, 49) != 0), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)));
            bus.iaddr   = {$urandom, $urandom};
            bus.daddr   = {$urandom, $urandom};
            bus.dstore  = {$urandom, $urandom};
            bus.ramload = $urandom;
            @(negedge CLK);
            check_model(i);
            to_next();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter_rr.md
Name: mem_arbiter_rr

Overview:
- Parametrised memory controller between CPUS private caches and the single shared RAM port.
- Each cache presents one instruction and one data request channel; the block arbitrates all 2*CPUS channels round-robin.
- Drives the RAM port and returns per-channel wait and load signals.
- Replaces the single-CPU controller in the multicore top level; cache coherence snooping is out of scope.

Parameters:
- CPUS, 2, number of caches served (1..8).
- WORD_W, 32, data word width.
- ADDR_W, 32, address width.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- nRST  in  1  reset, synchronous, active-low.
- iREN  in  CPUS  per-cache instruction read request.
- iaddr  in  CPUS*ADDR_W  instruction addresses; cache c occupies slice [c*ADDR_W +: ADDR_W].
- dREN  in  CPUS  per-cache data read request.
- dWEN  in  CPUS  per-cache data write request.
- daddr  in  CPUS*ADDR_W  data addresses, packed as iaddr.
- dstore  in  CPUS*WORD_W  data write values, packed per cache.
- iwait  out  CPUS  low only in the cycle the instruction read completes.
- dwait  out  CPUS  low only in the cycle the data access completes.
- iload  out  CPUS*WORD_W  instruction read data, valid when the matching iwait bit is low.
- dload  out  CPUS*WORD_W  data read data, valid when the matching dwait bit is low.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR.
- ram_err  out  1  one-cycle pulse when ramstate reports ERROR during a grant.

Behaviour:
- Channels: index 2c is cache c data; index 2c+1 is cache c instruction.
  - req[2c] = dREN[c] | dWEN[c].
  - req[2c+1] = iREN[c].
- Reset: in any cycle where nRST is low at the clock edge, the block goes to IDLE, ptr <= 0, owner <= 0.
  - Outputs after reset: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, all iwait/dwait=1, ram_err=0.
  - Reset during BUSY aborts the access with no ack.
- FSM has two states: IDLE and BUSY.
- IDLE:
  - RAM enables are 0.
  - If any req bit is set, owner <= first set index searching upward from ptr, modulo 2*CPUS; next state BUSY.
  - Grant is registered: first RAM enable appears one cycle after the request is seen.
- BUSY:
  - ramaddr, ramREN/ramWEN and ramstore follow the owner channel combinationally.
  - If dWEN and dREN are both high on a data channel, the access is a write; ramREN=0.
- ramstate ACCESS in BUSY:
  - The owner's wait bit is driven 0 for that single cycle; all other waits stay 1.
  - The owner's load slice = ramload. Non-owner load slices are 0; wait bits, not load values, qualify data.
  - Next state IDLE; ptr <= (owner+1) mod 2*CPUS.
- ramstate FREE or BUSY in BUSY: hold state, keep the enables asserted.
- ramstate ERROR in BUSY:
  - ram_err=1 for that cycle and the owner's wait stays 1.
  - Next state IDLE; ptr is unchanged, so the same channel is re-granted if it still requests.
- Owner withdraws its request while BUSY:
  - RAM enables drop that same cycle (combinationally 0).
  - Next state IDLE with no ack; ptr <= owner+1.
- Minimum completion latency:
  - Request seen in cycle N, enable driven in N+1, ack no earlier than N+1 if RAM answers ACCESS immediately.
  - Back-to-back grants have one IDLE cycle between them.
- Fairness: any continuously asserted request is served within 2*CPUS grants.
- CPUS=1 degenerates to data-then-instruction alternation.
- Every bit of iwait/dwait is 1 whenever its channel is not owner-acked, including idle channels.

Test Plan:
- Reset: hold nRST low 2 cycles with all requests high -> ramREN=ramWEN=0, all waits 1, ram_err=0; first grant goes to channel 0 (cache0 data).
- Single read: CPUS=2, iREN[1]=1, iaddr slice1=0x40, RAM returns ACCESS after 3 BUSY cycles with ramload=0xDEADBEEF -> ramaddr=0x40, ramREN=1; iwait[1] low exactly one cycle; iload slice1=0xDEADBEEF that cycle.
- Write priority: dREN[0]=dWEN[0]=1, daddr=0x100, dstore=0x12345678 -> ramWEN=1, ramREN=0, ramstore=0x12345678; dwait[0] low on ACCESS.
- Round-robin: all four channels request continuously, RAM returns ACCESS immediately -> grant order 0,1,2,3,0; each ack separated by one IDLE cycle.
- Error retry: granted channel 2 sees ramstate=3 -> ram_err pulses, dwait[1] stays 1; channel 2 is re-granted next and completes on ACCESS.
- Withdraw and mid-op reset: owner drops iREN mid-BUSY -> enables drop the same cycle, no ack. Separately, nRST low during BUSY -> IDLE next cycle, ptr=0, no ack.
